// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side buffer between the UART receiver and the host register file.
// Bytes are queued in a DEPTH-entry FIFO (16550 mode) or in a single
// holding register (16450 mode). The block flags overruns, raises a
// trigger-level interrupt and raises a character-timeout interrupt when
// data sits unread while the line is idle.
//
// Handshake: i_rx_flag is a one-cycle strobe that qualifies i_rx_data;
// i_rd is a one-cycle pop strobe that takes the head byte shown on
// o_rd_data (first-word-fall-through) and is ignored when empty. Neither
// side can be back-pressured; a write with no room is reported through
// o_overrun.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH   = 16,
  parameter int TO_BITS = 40
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_flag,
  input  logic                     i_fifo_en,
  input  logic                     i_fifo_clr,
  input  logic [1:0]               i_trig_lvl,
  input  logic [19:0]              i_bit_period,
  input  logic                     i_rd,
  input  logic                     i_ovr_clr,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_data_ready,
  output logic                     o_overrun,
  output logic                     o_trig_irq,
  output logic                     o_timeout_irq,
  output logic [0:0]               o_dbg_to_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(TO_BITS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          mode_q;
  logic          overrun_q;
  logic          trig_q;

  logic [0:0]    to_state;
  logic [19:0]   cyc_cnt;
  logic [BW-1:0] bit_cnt;
  logic          to_irq_q;

  logic          flush;
  logic [CW-1:0] cap;
  logic          do_rd;
  logic          has_room;
  logic          do_wr;
  logic          ovr_evt;
  logic          hold_ovw;
  logic [CW-1:0] thr;
  logic [19:0]   period_eff;

  // Per-edge decisions: flush beats everything, a pop frees a slot before
  // the write is judged, and a write with no room becomes an overrun.
  always_comb begin
    flush      = i_fifo_clr || (i_fifo_en != mode_q);
    cap        = mode_q ? CW'(DEPTH) : CW'(1);
    do_rd      = !flush && i_rd && (count != '0);
    has_room   = (count < cap) || do_rd;
    do_wr      = !flush && i_rx_flag && has_room;
    ovr_evt    = !flush && i_rx_flag && !has_room;
    hold_ovw   = ovr_evt && !mode_q;
    period_eff = (i_bit_period < 20'd2) ? 20'd2 : i_bit_period;
    count_nxt  = count;
    if (flush) begin
      count_nxt = '0;
    end else if (do_wr && !do_rd) begin
      count_nxt = count + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_nxt = count - CW'(1);
    end
    case (i_trig_lvl)
      2'd0:    thr = CW'(1);
      2'd1:    thr = CW'(4);
      2'd2:    thr = CW'(8);
      default: thr = CW'(14);
    endcase
  end

  // Storage array; holding-mode overrun replaces the single stored byte.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      if (do_wr) begin
        mem[wr_ptr] <= i_rx_data;
      end else if (hold_ovw) begin
        mem[rd_ptr] <= i_rx_data;
      end
    end
  end

  // Pointers, occupancy and the registered mode copy used for change detection.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mode_q <= i_fifo_en;
    end else begin
      mode_q <= i_fifo_en;
      count  <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + AW'(1);
        if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Sticky overrun; a new overrun on the same edge outranks the clear.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      overrun_q <= 1'b0;
    end else if (ovr_evt) begin
      overrun_q <= 1'b1;
    end else if (i_ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  // Trigger interrupt registered from next occupancy so outputs stay registered.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= i_fifo_en && (count_nxt >= thr);
    end
  end

  // Character-timeout machine: counts idle bit periods while data is held.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      to_state <= ST_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      to_irq_q <= 1'b0;
    end else if (flush || (count_nxt == '0)) begin
      to_state <= ST_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      to_irq_q <= 1'b0;
    end else if (do_wr || do_rd || (to_state == ST_IDLE)) begin
      // Activity (or first sight of data) restarts the idle measurement.
      to_state <= ST_COUNT;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      to_irq_q <= 1'b0;
    end else if (bit_cnt != BW'(TO_BITS)) begin
      // Counters hold once the limit is reached, keeping the flag set.
      if (cyc_cnt >= period_eff - 20'd1) begin
        cyc_cnt <= '0;
        bit_cnt <= bit_cnt + BW'(1);
        if (bit_cnt + BW'(1) == BW'(TO_BITS)) begin
          to_irq_q <= 1'b1;
        end
      end else begin
        cyc_cnt <= cyc_cnt + 20'd1;
      end
    end
  end

  assign o_rd_data      = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign o_count        = count;
  assign o_data_ready   = (count != '0);
  assign o_overrun      = overrun_q;
  assign o_trig_irq     = trig_q;
  assign o_timeout_irq  = to_irq_q;
  assign o_dbg_to_state = to_state;

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side buffer controller placed between the UART receiver (byte + one-cycle valid strobe) and the host register interface. It queues received bytes in a 16-entry FIFO (16550 mode) or a single holding register (16450 mode). It also flags overrun, raises a trigger-level interrupt, and raises a character-timeout interrupt when data sits unread while the line is idle.

## Interface
- DEPTH, 16, FIFO entries; power of two; o_count width is log2(DEPTH)+1.
- TO_BITS, 40, idle bit-periods (4 characters x 10 bits) before the timeout interrupt.
- i_sys_clk  in  1  system clock; all logic on rising edge; one clock domain.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte; valid only while i_rx_flag=1.
- i_rx_flag  in  1  one-cycle strobe from the receiver.
- i_fifo_en  in  1  1 = FIFO mode (DEPTH entries), 0 = holding-register mode (1 entry).
- i_fifo_clr  in  1  one-cycle flush pulse.
- i_trig_lvl  in  2  trigger threshold: 0→1, 1→4, 2→8, 3→14 bytes.
- i_bit_period  in  20  system clocks per bit; values 0 and 1 are treated as 2.
- i_rd  in  1  host pop strobe; ignored when empty.
- i_ovr_clr  in  1  clears o_overrun.
- o_rd_data  out  8  head byte (first-word-fall-through); 0 when empty.
- o_count  out  5  bytes held, 0..16.
- o_data_ready  out  1  o_count != 0.
- o_overrun  out  1  sticky overrun flag.
- o_trig_irq  out  1  i_fifo_en && o_count >= threshold.
- o_timeout_irq  out  1  character-timeout interrupt.

## Operation
- Storage: 16x8 array, write pointer, read pointer and count. Pointers wrap modulo 16. The array itself is not reset.
- Capacity: DEPTH when i_fifo_en=1, 1 when i_fifo_en=0.
- Mode change: any change of i_fifo_en is detected against a registered copy. It flushes exactly like i_fifo_clr on the edge the change is first seen.
- Write: on i_rx_flag, the byte is accepted if count < capacity.
- Full, FIFO mode: the incoming byte is discarded, stored data is unchanged, and o_overrun is set.
- Full, holding mode: the incoming byte overwrites the single entry, count stays 1, and o_overrun is set.
- Read: on i_rd with count > 0, the read pointer advances and count decrements. i_rd on empty has no effect.
- Simultaneous read and write when full: the pop frees a slot first. The write is accepted, count is unchanged, and no overrun occurs.
- Simultaneous read and write when empty: the write is accepted, the read is ignored, and count becomes 1.
- Flush (i_fifo_clr or mode change): pointers and count go to 0, and the timeout state clears. A write or read on the same edge is ignored. o_overrun is unaffected.
- Overrun priority: i_ovr_clr clears o_overrun, except that a new overrun on the same edge wins and the flag stays 1.
- Timeout machine, states IDLE and COUNT:
  - Uses a cycle counter (0..period-1) and a bit counter (0..TO_BITS).
  - IDLE→COUNT when count > 0.
  - In COUNT, the bit counter increments on each cycle-counter wrap.
  - An accepted write, an accepted read, or a flush zeroes both counters and clears o_timeout_irq. After a read it restarts COUNT only if count is still > 0.
  - Bit counter reaching TO_BITS sets o_timeout_irq. The counters then hold and the flag stays 1 until cleared.
  - count = 0 → IDLE, o_timeout_irq = 0.
  - Timeout operates in both modes.
- Width rules: count is 5 bits with no wrap, saturating at capacity. Threshold compare is unsigned.

## Timing
- Reset values: o_count=0, o_data_ready=0, o_rd_data=0, o_overrun=0, o_trig_irq=0, o_timeout_irq=0; timeout in IDLE; mode copy = i_fifo_en sampled at reset.
- Write latency: an i_rx_flag sampled at edge N is reflected in o_count, o_data_ready, o_rd_data and o_trig_irq immediately after edge N.
- Read: o_rd_data shows the next entry immediately after the popping edge.
- Outputs are decoded from registered state only, with no input-to-output combinational path.
- Timeout: with period P, o_timeout_irq rises exactly TO_BITS*P cycles after the last accepted write or read, provided count stays > 0.
- Reset asserted mid-operation: everything returns to reset values on that edge, and inputs are ignored while i_sys_rst=1.

## Test plan
- FIFO mode, write 0x11..0x1F (15 bytes), then pop 15: o_count climbs to 15. With i_trig_lvl=3, o_trig_irq rises at the 14th write and drops when count reaches 13. Data pops in order 0x11..0x1F.
- FIFO mode, write 17 bytes 0x00..0x10: count=16, o_overrun=1, and the head stays 0x00 with 0x10 discarded. On a full FIFO, pulse i_rd with i_rx_flag (0xAA): count stays 16 and the tail is 0xAA. Then pulse i_ovr_clr: o_overrun clears.
- Holding mode, write 0x55 then 0x66 without a read: count=1, o_rd_data=0x66, o_overrun=1, o_trig_irq stays 0.
- i_bit_period=4, write one byte, no reads: o_timeout_irq rises exactly 160 cycles after the write edge. An i_rd clears it and count=0 keeps it low. A repeat where a write arrives at cycle 100 delays the rise to cycle 260.
- With 5 bytes stored, toggle i_fifo_en: count→0 on the following edge, o_timeout_irq=0, o_overrun unchanged. Then assert i_sys_rst during a write burst: all outputs return to 0.
